gray_counter: RTL and testbench

Registered up/down counter that produces each count as a binary value and as its Gray-code equivalent. Both encodings update on the same clock edge, so they always match.
Sits directly upstream of a Gray-code consumer: pointer synchronisers, encoder emulation and display logic.
Presents each value through a valid/ready handshake. Supports parallel load of a Gray-coded value.

---
 rtl/gray_pkg.sv | 22 ++
 rtl/gray_to_bin.sv | 15 +
 rtl/gray_counter.sv | 117 +++++++++++
 tb/tb_gray_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared constants and helpers for the Gray-code counter.
package gray_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned MAX_WIDTH     = 32;

    // All-ones value for a counter of width w (w clamped to MAX_WIDTH).
    function automatic logic [MAX_WIDTH-1:0] max_count(input int unsigned w);
        logic [MAX_WIDTH:0] one;
        one = (MAX_WIDTH+1)'(1);
        if (w >= MAX_WIDTH) begin
            return '1;
        end
        return MAX_WIDTH'((one << w) - one);
    endfunction

    // Binary to reflected Gray code.
    function automatic logic [MAX_WIDTH-1:0] bin_to_gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter used for the parallel-load path.
module gray_to_bin #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it; written as a
    // reduction so no bit depends on another output bit.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_counter.sv
// Registered up/down counter presenting binary and Gray encodings together,
// with a valid/ready output handshake, Gray parallel load and wrap/saturate ends.
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter bit          WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] bin_q,
    output logic [WIDTH-1:0] gray_q,
    output logic             tc,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(max_count(WIDTH));

    logic [WIDTH-1:0] load_bin_c;
    logic             advance_c;
    logic             at_max_c;
    logic             at_zero_c;

    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_d;
    logic             valid_d;
    logic             tc_d;
    logic             sat_d;

    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_gray_to_bin (
        .gray (load_gray),
        .bin  (load_bin_c)
    );

    // A value is consumed only when the consumer takes it and no load competes.
    assign advance_c = en & out_valid & out_ready & ~load;
    assign at_max_c  = (bin_q == MAX_VAL);
    assign at_zero_c = (bin_q == '0);

    // Next-state: load beats advance beats hold; tc defaults low every cycle.
    always_comb begin
        bin_d   = bin_q;
        gray_d  = gray_q;
        valid_d = 1'b1;
        tc_d    = 1'b0;
        sat_d   = sat;

        if (load) begin
            bin_d  = load_bin_c;
            gray_d = load_gray;
            sat_d  = 1'b0;
        end else if (advance_c) begin
            if (up_dn) begin
                if (at_max_c) begin
                    if (WRAP) begin
                        bin_d = '0;
                        tc_d  = 1'b1;
                    end else begin
                        // Pulse only on the first blocked attempt.
                        sat_d = 1'b1;
                        tc_d  = ~sat;
                    end
                end else begin
                    // Any real movement leaves the limit, so saturation clears.
                    bin_d = bin_q + WIDTH'(1);
                    sat_d = 1'b0;
                end
            end else begin
                if (at_zero_c) begin
                    if (WRAP) begin
                        bin_d = MAX_VAL;
                        tc_d  = 1'b1;
                    end else begin
                        sat_d = 1'b1;
                        tc_d  = ~sat;
                    end
                end else begin
                    bin_d = bin_q - WIDTH'(1);
                    sat_d = 1'b0;
                end
            end
            gray_d = WIDTH'(bin_to_gray(MAX_WIDTH'(bin_d)));
        end

        if (!WRAP) begin
            sat_d = sat_d;
        end else begin
            sat_d = 1'b0;
        end
    end

    // State register with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q     <= '0;
            gray_q    <= '0;
            out_valid <= 1'b0;
            tc        <= 1'b0;
            sat       <= 1'b0;
        end else begin
            bin_q     <= bin_d;
            gray_q    <= gray_d;
            out_valid <= valid_d;
            tc        <= tc_d;
            sat       <= sat_d;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench: one wrapping and one saturating instance share stimulus.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_gray;
    logic       out_ready;

    logic       w_valid, w_tc, w_sat;
    logic [3:0] w_bin, w_gray;
    logic       s_valid, s_tc, s_sat;
    logic [3:0] s_bin, s_gray;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_gray(load_gray), .out_ready(out_ready), .out_valid(w_valid),
        .bin_q(w_bin), .gray_q(w_gray), .tc(w_tc), .sat(w_sat)
    );

    gray_counter #(.WIDTH(4), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_gray(load_gray), .out_ready(out_ready), .out_valid(s_valid),
        .bin_q(s_bin), .gray_q(s_gray), .tc(s_tc), .sat(s_sat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0;
        load_gray = 4'b0000; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({w_valid, w_bin, w_gray, w_tc, w_sat} !== 11'd0) begin
                bad++; $display("FAIL reset_wrap cyc=%0d got=%b exp=0", i, {w_valid, w_bin, w_gray, w_tc, w_sat});
            end
            total++;
            if ({s_valid, s_bin, s_gray, s_tc, s_sat} !== 11'd0) begin
                bad++; $display("FAIL reset_sat cyc=%0d got=%b exp=0", i, {s_valid, s_bin, s_gray, s_tc, s_sat});
            end
        end
        rst_n = 1'b1;
        tick();
        total++;
        if ({w_valid, w_bin, w_gray, w_tc} !== {1'b1, 4'd0, 4'b0000, 1'b0}) begin
            bad++; $display("FAIL release got=%b exp=%b", {w_valid, w_bin, w_gray, w_tc}, {1'b1, 9'd0});
        end
    endtask

    task automatic test_count_wrap();
        logic [3:0] exp_g [17];
        logic [3:0] prev;
        exp_g = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                  4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        en = 1'b1; up_dn = 1'b1; out_ready = 1'b1;
        prev = w_gray;
        for (int i = 1; i < 17; i++) begin
            tick();
            total++;
            if (w_gray !== exp_g[i] || w_bin !== 4'(i)) begin
                bad++; $display("FAIL count_up step=%0d got=%b/%b exp=%b/%b", i, w_bin, w_gray, 4'(i), exp_g[i]);
            end
            total++;
            if (w_tc !== (i == 16)) begin
                bad++; $display("FAIL count_tc step=%0d got=%b exp=%b", i, w_tc, (i == 16));
            end
            total++;
            if ($countones(w_gray ^ prev) != 1) begin
                bad++; $display("FAIL one_bit step=%0d got=%b prev=%b", i, w_gray, prev);
            end
            prev = w_gray;
        end
        total++;
        if ({s_bin, s_sat, s_tc} !== {4'd15, 1'b1, 1'b1}) begin
            bad++; $display("FAIL sat_top got=%b exp=%b", {s_bin, s_sat, s_tc}, {4'd15, 2'b11});
        end
        tick();
        total++;
        if ({s_bin, s_sat, s_tc, w_bin} !== {4'd15, 1'b1, 1'b0, 4'd1}) begin
            bad++; $display("FAIL sat_top_hold got=%b exp=%b", {s_bin, s_sat, s_tc, w_bin}, {4'd15, 2'b10, 4'd1});
        end
        up_dn = 1'b0;
        tick();
        total++;
        if ({s_bin, s_sat, w_bin, w_tc} !== {4'd14, 1'b0, 4'd0, 1'b0}) begin
            bad++; $display("FAIL sat_top_clear got=%b exp=%b", {s_bin, s_sat, w_bin, w_tc}, {4'd14, 1'b0, 4'd0, 1'b0});
        end
    endtask

    task automatic test_backpressure();
        load = 1'b1; load_gray = 4'b0111; up_dn = 1'b1; en = 1'b1; out_ready = 1'b1;
        tick();
        load = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({w_bin, w_gray, w_tc, w_valid} !== {4'd5, 4'b0111, 1'b0, 1'b1}) begin
                bad++; $display("FAIL stall cyc=%0d got=%b exp=%b", i, {w_bin, w_gray, w_tc, w_valid}, {4'd5, 4'b0111, 2'b01});
            end
        end
        out_ready = 1'b1;
        tick();
        total++;
        if ({w_bin, w_gray} !== {4'd6, 4'b0101}) begin
            bad++; $display("FAIL resume got=%b exp=%b", {w_bin, w_gray}, {4'd6, 4'b0101});
        end
    endtask

    task automatic test_load_priority();
        load = 1'b1; load_gray = 4'b1101; en = 1'b1; out_ready = 1'b1; up_dn = 1'b1;
        tick();
        total++;
        if ({w_bin, w_gray, s_bin, s_gray} !== {4'b1001, 4'b1101, 4'b1001, 4'b1101}) begin
            bad++; $display("FAIL load_wins got=%b exp=%b", {w_bin, w_gray, s_bin, s_gray}, {2{4'b1001, 4'b1101}});
        end
        load = 1'b0; up_dn = 1'b0;
        tick();
        total++;
        if ({w_bin, w_gray, w_tc} !== {4'b1000, 4'b1100, 1'b0}) begin
            bad++; $display("FAIL dir_change got=%b exp=%b", {w_bin, w_gray, w_tc}, {4'b1000, 4'b1100, 1'b0});
        end
    endtask

    task automatic test_bottom_limit();
        load = 1'b1; load_gray = 4'b0000; up_dn = 1'b0; en = 1'b1; out_ready = 1'b1;
        tick();
        load = 1'b0;
        tick();
        total++;
        if ({w_bin, w_gray, w_tc} !== {4'b1111, 4'b1000, 1'b1}) begin
            bad++; $display("FAIL wrap_down got=%b exp=%b", {w_bin, w_gray, w_tc}, {4'b1111, 4'b1000, 1'b1});
        end
        total++;
        if ({s_bin, s_gray, s_sat, s_tc} !== {4'd0, 4'd0, 1'b1, 1'b1}) begin
            bad++; $display("FAIL sat_bottom got=%b exp=%b", {s_bin, s_gray, s_sat, s_tc}, {8'd0, 2'b11});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({s_bin, s_sat, s_tc, w_tc} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
                bad++; $display("FAIL sat_hold cyc=%0d got=%b exp=%b", i, {s_bin, s_sat, s_tc, w_tc}, {4'd0, 3'b100});
            end
        end
        up_dn = 1'b1;
        tick();
        total++;
        if ({s_bin, s_gray, s_sat, s_tc} !== {4'd1, 4'b0001, 1'b0, 1'b0}) begin
            bad++; $display("FAIL sat_release got=%b exp=%b", {s_bin, s_gray, s_sat, s_tc}, {4'd1, 4'b0001, 2'b00});
        end
        total++;
        if (w_bin !== 4'd13) begin
            bad++; $display("FAIL wrap_after got=%0d exp=13", w_bin);
        end
    endtask

    task automatic test_reset_beats_load();
        load = 1'b1; load_gray = 4'b0000; en = 1'b1; up_dn = 1'b1; out_ready = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        total++;
        if ({w_bin, w_gray} !== {4'd7, 4'b0100}) begin
            bad++; $display("FAIL count_to_7 got=%b exp=%b", {w_bin, w_gray}, {4'd7, 4'b0100});
        end
        rst_n = 1'b0; load = 1'b1; load_gray = 4'b1111;
        tick();
        total++;
        if ({w_valid, w_bin, w_gray, w_tc, w_sat} !== 11'd0) begin
            bad++; $display("FAIL reset_wins got=%b exp=0", {w_valid, w_bin, w_gray, w_tc, w_sat});
        end
        total++;
        if ({s_valid, s_bin, s_gray, s_tc, s_sat} !== 11'd0) begin
            bad++; $display("FAIL reset_wins_sat got=%b exp=0", {s_valid, s_bin, s_gray, s_tc, s_sat});
        end
        rst_n = 1'b1; load = 1'b0;
        tick();
        total++;
        if ({w_valid, w_bin} !== {1'b1, 4'd0}) begin
            bad++; $display("FAIL rerelease got=%b exp=%b", {w_valid, w_bin}, {1'b1, 4'd0});
        end
    endtask

    initial begin
        test_reset();
        test_count_wrap();
        test_backpressure();
        test_load_priority();
        test_bottom_limit();
        test_reset_beats_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
